// File: rtl/id_stage.sv
// RV32I decode stage: fetch handshake, register read with bypass/stall,
// branch/jump resolution and the decoded bundle handed to execute.
module id_stage #(
    parameter bit FWD_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fs_valid,
    input  logic [31:0] fs_pc,
    input  logic [31:0] fs_inst,
    output logic        ds_ready,
    input  logic        es_ready,
    output logic        ds_to_es_valid,
    output logic [31:0] pre_pc,
    output logic        pc_src,
    output logic [4:0]  rf_raddr1,
    output logic [4:0]  rf_raddr2,
    input  logic [31:0] rf_rdata1,
    input  logic [31:0] rf_rdata2,
    input  logic        es_wen,
    input  logic        ms_wen,
    input  logic        ws_wen,
    input  logic [4:0]  es_rd,
    input  logic [4:0]  ms_rd,
    input  logic [4:0]  ws_rd,
    input  logic [31:0] es_wdata,
    input  logic [31:0] ms_wdata,
    input  logic [31:0] ws_wdata,
    input  logic        es_is_load,
    output logic [31:0] ds_pc,
    output logic [3:0]  ds_alu_op,
    output logic [31:0] ds_src1,
    output logic [31:0] ds_src2,
    output logic [31:0] ds_store_data,
    output logic [4:0]  ds_rd,
    output logic        ds_rf_we,
    output logic        ds_mem_re,
    output logic        ds_mem_we,
    output logic        ds_illegal
);

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,  ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
        ALU_SLTU = 4'd4,  ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
        ALU_OR   = 4'd8,  ALU_AND = 4'd9, ALU_PASS_B = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {SRC1_RS1, SRC1_PC, SRC1_ZERO} src1_sel_e;
    typedef enum logic [1:0] {SRC2_RS2, SRC2_IMM, SRC2_FOUR} src2_sel_e;

    typedef struct packed {
        logic        stall;
        logic [31:0] data;
    } operand_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    logic        ds_valid_q, ds_valid_d;
    logic [31:0] ds_pc_q, ds_pc_d;
    logic [31:0] ds_inst_q, ds_inst_d;

    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    logic        illegal, use_rs1, use_rs2, writes_rd, mem_re, mem_we;
    logic        is_branch, is_jal, is_jalr;
    alu_op_e     alu_op;
    src1_sel_e   src1_sel;
    src2_sel_e   src2_sel;
    logic [31:0] imm;

    operand_t    opnd1, opnd2;
    logic        ds_ready_go, br_cond, taken;
    logic [31:0] target;

    assign opcode = ds_inst_q[6:0];
    assign rd     = ds_inst_q[11:7];
    assign funct3 = ds_inst_q[14:12];
    assign rs1    = ds_inst_q[19:15];
    assign rs2    = ds_inst_q[24:20];
    assign funct7 = ds_inst_q[31:25];

    assign imm_i = {{20{ds_inst_q[31]}}, ds_inst_q[31:20]};
    assign imm_s = {{20{ds_inst_q[31]}}, ds_inst_q[31:25], ds_inst_q[11:7]};
    assign imm_b = {{19{ds_inst_q[31]}}, ds_inst_q[31], ds_inst_q[7],
                    ds_inst_q[30:25], ds_inst_q[11:8], 1'b0};
    assign imm_u = {ds_inst_q[31:12], 12'b0};
    assign imm_j = {{11{ds_inst_q[31]}}, ds_inst_q[31], ds_inst_q[19:12],
                    ds_inst_q[20], ds_inst_q[30:21], 1'b0};

    // alt selects SUB/SRA; callers only raise it where that encoding is legal.
    function automatic alu_op_e alu_from_funct(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // Youngest in-flight writer wins; a load in es (or any match without bypass) stalls.
    function automatic operand_t resolve(
        input logic        used,
        input logic [4:0]  rs,
        input logic [31:0] rf_data,
        input logic        e_wen, input logic [4:0] e_rd, input logic [31:0] e_data,
        input logic        e_load,
        input logic        m_wen, input logic [4:0] m_rd, input logic [31:0] m_data,
        input logic        w_wen, input logic [4:0] w_rd, input logic [31:0] w_data
    );
        operand_t r;
        r.stall = 1'b0;
        r.data  = rf_data;
        if (rs == 5'd0) begin
            r.data = '0;
        end else if (e_wen && e_rd == rs) begin
            r.data  = e_data;
            r.stall = used && (e_load || !FWD_EN);
        end else if (m_wen && m_rd == rs) begin
            r.data  = m_data;
            r.stall = used && !FWD_EN;
        end else if (w_wen && w_rd == rs) begin
            r.data  = w_data;
            r.stall = used && !FWD_EN;
        end
        return r;
    endfunction

    always_comb begin
        // NOTE: every signal gets a default first so no decode path infers a latch.
        illegal   = 1'b0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        writes_rd = 1'b0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        is_branch = 1'b0;
        is_jal    = 1'b0;
        is_jalr   = 1'b0;
        alu_op    = ALU_ADD;
        src1_sel  = SRC1_RS1;
        src2_sel  = SRC2_RS2;
        imm       = imm_i;
        case (opcode)
            OPC_LUI: begin
                writes_rd = 1'b1;
                alu_op    = ALU_PASS_B;
                src1_sel  = SRC1_ZERO;
                src2_sel  = SRC2_IMM;
                imm       = imm_u;
            end
            OPC_AUIPC: begin
                writes_rd = 1'b1;
                src1_sel  = SRC1_PC;
                src2_sel  = SRC2_IMM;
                imm       = imm_u;
            end
            OPC_JAL: begin
                writes_rd = 1'b1;
                is_jal    = 1'b1;
                src1_sel  = SRC1_PC;
                src2_sel  = SRC2_FOUR;
                imm       = imm_j;
            end
            OPC_JALR: begin
                if (funct3 == 3'b000) begin
                    writes_rd = 1'b1;
                    is_jalr   = 1'b1;
                    use_rs1   = 1'b1;
                    src1_sel  = SRC1_PC;
                    src2_sel  = SRC2_FOUR;
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_BRANCH: begin
                if (funct3 != 3'b010 && funct3 != 3'b011) begin
                    is_branch = 1'b1;
                    use_rs1   = 1'b1;
                    use_rs2   = 1'b1;
                    imm       = imm_b;
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_LOAD: begin
                if (funct3 == 3'b010) begin
                    writes_rd = 1'b1;
                    use_rs1   = 1'b1;
                    mem_re    = 1'b1;
                    src2_sel  = SRC2_IMM;
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_STORE: begin
                if (funct3 == 3'b010) begin
                    use_rs1  = 1'b1;
                    use_rs2  = 1'b1;
                    mem_we   = 1'b1;
                    src2_sel = SRC2_IMM;
                    imm      = imm_s;
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                if ((funct3 == 3'b001 && funct7 != 7'b0000000) ||
                    (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000)) begin
                    illegal = 1'b1;
                end else begin
                    writes_rd = 1'b1;
                    use_rs1   = 1'b1;
                    src2_sel  = SRC2_IMM;
                    alu_op    = alu_from_funct(funct3, funct3 == 3'b101 && funct7[5]);
                end
            end
            OPC_OP: begin
                if (funct7 == 7'b0000000 ||
                    (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
                    writes_rd = 1'b1;
                    use_rs1   = 1'b1;
                    use_rs2   = 1'b1;
                    alu_op    = alu_from_funct(funct3, funct7[5]);
                end else begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase
    end

    assign opnd1 = resolve(use_rs1, rs1, rf_rdata1, es_wen, es_rd, es_wdata, es_is_load,
                           ms_wen, ms_rd, ms_wdata, ws_wen, ws_rd, ws_wdata);
    assign opnd2 = resolve(use_rs2, rs2, rf_rdata2, es_wen, es_rd, es_wdata, es_is_load,
                           ms_wen, ms_rd, ms_wdata, ws_wen, ws_rd, ws_wdata);

    assign ds_ready_go    = !(opnd1.stall || opnd2.stall);
    assign ds_ready       = !ds_valid_q || (ds_ready_go && es_ready);
    assign ds_to_es_valid = ds_valid_q && ds_ready_go;

    always_comb begin
        br_cond = 1'b0;
        case (funct3)
            3'b000:  br_cond = opnd1.data == opnd2.data;
            3'b001:  br_cond = opnd1.data != opnd2.data;
            3'b100:  br_cond = $signed(opnd1.data) <  $signed(opnd2.data);
            3'b101:  br_cond = $signed(opnd1.data) >= $signed(opnd2.data);
            3'b110:  br_cond = opnd1.data <  opnd2.data;
            3'b111:  br_cond = opnd1.data >= opnd2.data;
            default: br_cond = 1'b0;
        endcase
    end

    assign taken  = is_jal || is_jalr || (is_branch && br_cond);
    assign target = is_jalr ? ((opnd1.data + imm) & ~32'd1) : (ds_pc_q + imm);
    assign pre_pc = target;
    assign pc_src = ds_valid_q && ds_ready_go && es_ready && taken;

    assign rf_raddr1     = rs1;
    assign rf_raddr2     = rs2;
    assign ds_pc         = ds_pc_q;
    assign ds_alu_op     = alu_op;
    assign ds_src1       = (src1_sel == SRC1_PC)   ? ds_pc_q :
                           (src1_sel == SRC1_ZERO) ? 32'd0   : opnd1.data;
    assign ds_src2       = (src2_sel == SRC2_IMM)  ? imm     :
                           (src2_sel == SRC2_FOUR) ? 32'd4   : opnd2.data;
    assign ds_store_data = opnd2.data;
    assign ds_rd         = rd;
    assign ds_rf_we      = writes_rd && (rd != 5'd0);
    assign ds_mem_re     = mem_re;
    assign ds_mem_we     = mem_we;
    assign ds_illegal    = illegal;

    // The successor accepted alongside a redirect is wrong-path and is dropped.
    always_comb begin
        ds_valid_d = ds_valid_q;
        ds_pc_d    = ds_pc_q;
        ds_inst_d  = ds_inst_q;
        if (ds_ready) begin
            ds_valid_d = fs_valid && !pc_src;
            if (fs_valid) begin
                ds_pc_d   = fs_pc;
                ds_inst_d = fs_inst;
            end
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ds_valid_q <= 1'b0;
            ds_pc_q    <= '0;
            ds_inst_q  <= 32'h0000_0013;
        end else begin
            ds_valid_q <= ds_valid_d;
            ds_pc_q    <= ds_pc_d;
            ds_inst_q  <= ds_inst_d;
        end
    end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Decode stage sitting directly downstream of the fetch stage. It consumes fs_valid/fs_pc/fs_inst through a valid/allowin handshake and returns ds_ready to fetch.
- Decodes RV32I (LUI, AUIPC, JAL, JALR, BRANCH, LW, SW, OP-IMM, OP) and reads the register file. Resolves operand hazards by bypass or stall.
- Resolves branches and jumps, driving pre_pc/pc_src back to fetch. Produces a decoded bundle for the execute stage.

Parameters:
- FWD_EN, 1, 1 = bypass from es/ms/ws; 0 = stall on any RAW hazard against an in-flight writer.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active low
- fs_valid  in  1  fetch holds a valid instruction
- fs_pc  in  32  PC of fs_inst
- fs_inst  in  32  instruction word aligned with fs_pc
- ds_ready  out  1  decode allowin to fetch
- es_ready  in  1  execute allowin
- ds_to_es_valid  out  1  bundle valid toward execute
- pre_pc  out  32  redirect target
- pc_src  out  1  redirect strobe
- rf_raddr1/rf_raddr2  out  5  regfile read addresses (rs1/rs2)
- rf_rdata1/rf_rdata2  in  32  regfile read data (combinational)
- es_wen/ms_wen/ws_wen  in  1  stage is valid and writes rd
- es_rd/ms_rd/ws_rd  in  5  destination register of that stage
- es_wdata/ms_wdata/ws_wdata  in  32  result of that stage
- es_is_load  in  1  es instruction is LW (result not yet available)
- ds_pc  out  32  PC of decoded instruction
- ds_alu_op  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B
- ds_src1/ds_src2  out  32  ALU operands
- ds_store_data  out  32  rs2 value (after bypass) for SW
- ds_rd  out  5  destination register
- ds_rf_we  out  1  writes rd (forced 0 when rd == x0)
- ds_mem_re/ds_mem_we  out  1  LW / SW
- ds_illegal  out  1  unrecognised opcode/funct

Behaviour:
- State: ds_valid, ds_pc_r, ds_inst_r. Reset values: ds_valid = 0, ds_pc_r = 0, ds_inst_r = 32'h00000013 (NOP).
- Handshake:
  - ds_ready = !ds_valid || (ds_ready_go && es_ready).
  - ds_to_es_valid = ds_valid && ds_ready_go.
  - When ds_ready: ds_valid <= fs_valid && !pc_src. ds_pc_r/ds_inst_r load fs_pc/fs_inst only if fs_valid.
- Latency: one cycle from fetch handoff to bundle valid. Outputs are combinational from the registers, the regfile and bypass inputs.
- Operand select, per used source (rs != x0), priority es > ms > ws > regfile:
  - es match with es_is_load forces stall.
  - FWD_EN = 0: any match forces stall.
  - rs == x0 always reads 0.
  - Unused sources never stall; rs2 is unused for I/U/J types.
- ds_ready_go = !stall.
- Decode:
  - OP/OP-IMM map funct3/funct7 to ALU op. SRAI/SRA use funct7[5]; SUB is valid for OP only.
  - LUI: src2 = imm, op PASS_B.
  - AUIPC: src1 = pc, src2 = imm, ADD.
  - JAL/JALR: src1 = pc, src2 = 4, ADD.
  - LW/SW: src1 = rs1, src2 = imm, ADD.
  - Branch: rf_we = 0, no memory access.
  - Immediates are sign-extended per I/S/B/U/J format.
- Illegal instruction: ds_illegal = 1, rf_we/mem_re/mem_we = 0, no redirect. It still passes down the pipeline.
- Branch resolution, computed in ds from bypassed operands:
  - BEQ/BNE/BLT/BGE use signed compare; BLTU/BGEU use unsigned.
  - Taken target: B/JAL = pc + imm; JALR = (rs1 + imm) & ~1. Wrap modulo 2^32.
- pc_src = ds_valid && ds_ready_go && es_ready && taken. pre_pc = target (don't-care when pc_src = 0).
  - pc_src is high exactly one cycle per redirect.
  - The fetch-side instruction accepted in that same cycle is the wrong-path successor and is dropped (ds_valid <= 0).
- A stall holds all registers. pc_src stays 0 while stalled.
- es_ready = 0 with ds_valid: ds_ready = 0 and the bundle is held stable.
- Reset asserted mid-operation clears ds_valid immediately, so ds_to_es_valid and pc_src drop asynchronously.

Test Plan:
- Reset release with fs_valid = 1, fs_pc = 4, fs_inst = ADDI x1, x0, 5 (0x00500093) -> next cycle ds_to_es_valid = 1, ds_alu_op = 0, ds_src1 = 0, ds_src2 = 5, ds_rd = 1, ds_rf_we = 1.
- Load-use: es_wen = 1, es_is_load = 1, es_rd = 2; ds holds ADD x3, x2, x2 -> ds_ready = 0 and ds_to_es_valid = 0. With es cleared and ms_rd = 2, ms_wdata = 7 the next cycle -> src1 = src2 = 7, ds_ready = 1.
- Bypass priority: es_rd = ms_rd = ws_rd = 5 with data 1/2/3 and ds reading x5 -> ds_src1 = 1. With FWD_EN = 0 -> stall.
- BEQ x0, x0, +16 at pc 0x100, es_ready = 1 -> pc_src = 1 for one cycle, pre_pc = 0x110. The fs instruction at 0x104 is dropped (ds_valid = 0 next cycle).
- JALR x1, 0(x6) with rf_rdata1 = 0x203 -> pre_pc = 0x202, ds_src1 = pc, ds_src2 = 4, ds_rd = 1. With es_ready = 0 -> pc_src = 0 and outputs held until es_ready = 1.
- fs_inst = 0xFFFFFFFF -> ds_illegal = 1, rf_we = mem_we = mem_re = 0, pc_src = 0.
- rst_n pulsed low mid-stall -> ds_valid = 0 immediately, ds_ready = 1 afterward.
